mem_stage_arbiter: RTL
======================

# mem_stage_arbiter

Two-core data-memory arbiter sitting between the MEM stage of each core's pipeline (the EX/MEM register outputs) and a single shared data-memory port. It accepts one load or store per core, grants the port round-robin, and sequences one outstanding memory transaction at a time. It stalls each requesting core's pipeline until that core's access completes, and returns load data with a one-cycle done indication.

## Interface
Parameters:
- DATA_WIDTH, 32, data and store-data width
- ADDRESS_BITS, 20, memory address width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- cN_load  in  1  core N (N=0,1) MEM-stage load request
- cN_store  in  1  core N MEM-stage store request
- cN_address  in  ADDRESS_BITS  core N address (ALU result)
- cN_store_data  in  DATA_WIDTH  core N store data
- cN_stall  out  1  hold core N pipeline (combinational)
- cN_done  out  1  one-cycle pulse: core N access complete
- cN_load_data  out  DATA_WIDTH  load result, valid while cN_done=1
- mem_req  out  1  memory request valid
- mem_we  out  1  1=store, 0=load
- mem_address  out  ADDRESS_BITS  request address
- mem_wdata  out  DATA_WIDTH  request store data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  DATA_WIDTH  load data

## Operation
- Request for core N: cN_req = cN_load | cN_store. If both are high, it is treated as a store.
- FSM states: IDLE, REQ, WAIT_RD, DONE.
- IDLE: if any cN_req is high, pick the winner and latch owner, we, address, wdata. Go to REQ. Otherwise stay in IDLE.
- Winner selection: a single requester wins. If both request, the core other than last_grant wins. last_grant updates on every grant.
- REQ: mem_req=1 with the latched fields.
  - If mem_ready=1 and we=1: go to DONE.
  - If mem_ready=1 and we=0: go to WAIT_RD.
  - If mem_ready=0: stay in REQ with all fields held stable.
- WAIT_RD: on mem_rvalid=1, latch mem_rdata and go to DONE. Otherwise stay.
- DONE: assert c{owner}_done=1, drive c{owner}_load_data from the latch (0 for stores), then go to IDLE.
- cN_stall = cN_req & ~(state==DONE & owner==N).
- A requester that loses arbitration stays stalled until it is granted and completes.
- Requests deasserted mid-transaction do not abort it; the transaction finishes and the done pulse still fires.
- mem_rvalid outside WAIT_RD is ignored.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (core 0 wins the first tie).
  - mem_req=0, mem_we=0, mem_address=0, mem_wdata=0.
  - cN_done=0, cN_load_data=0, owner=0.
- Reset mid-transaction: return to IDLE the next edge; any outstanding response is dropped. cN_stall still follows the combinational equation.
- Store latency with mem_ready held high: request seen in cycle 0, mem_req in cycle 1, done in cycle 2. The core is stalled in cycles 0–1.
- Load latency with mem_rvalid k cycles after accept (k≥1): done in cycle 2+k.
- A new arbitration happens no earlier than the cycle after DONE. Back-to-back grants are therefore at least 3 cycles apart.
- mem_* outputs are registered; cN_stall is combinational from the cN_* inputs and state.

## Structure
- Shared package holds:
  - the state encoding (localparams IDLE=2'd0, REQ=2'd1, WAIT_RD=2'd2, DONE=2'd3)
  - the owner encoding constants
- One natural sub-module, rr_arb2: a 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_idx.
  - Combinational; last_grant is held in the parent.

## Test plan
- Reset, then a core-0 store of 0xDEADBEEF to 0x00010 with mem_ready=1: mem_req/mem_we high in cycle 1, c0_done in cycle 2, c0_stall high for cycles 0–1 only.
- Core-1 load from 0x00020 with mem_rvalid=1 and mem_rdata=0x12345678 three cycles after accept: c1_done asserts with c1_load_data=0x12345678, and c1_stall is high in every earlier cycle.
- Both cores request loads simultaneously, repeated 4 times: grants alternate 0,1,0,1, and the loser's stall stays high until its own done.
- mem_ready held low 5 cycles in REQ: mem_req, mem_address and mem_wdata stay stable, and the FSM advances only on the first mem_ready=1.
- Reset asserted in WAIT_RD, then mem_rvalid=1 after reset: no cN_done pulse, and the FSM is in IDLE with last_grant=1.
- c0_load and c0_store both high: the request issues with mem_we=1.

Source files
------------

// File: rtl/mem_stage_arbiter_pkg.sv
// Shared types for the two-core data-memory arbiter: FSM encoding, owner
// encoding and the debug view of the arbiter's internal state.
package mem_stage_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam logic OWNER_C0 = 1'b0;
    localparam logic OWNER_C1 = 1'b1;

    typedef struct packed {
        arb_state_t state;
        logic       owner;
        logic       last_grant;
    } arb_dbg_t;

endpackage

// File: rtl/mem_stage_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the core that
// was not granted last time wins. The last-grant flop lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |req;

    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_arbiter.sv
// Arbitrates the MEM-stage loads/stores of two cores onto one data-memory
// port, one outstanding transaction at a time, stalling each requester until done.
module mem_stage_arbiter
    import mem_stage_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    c0_load,
    input  logic                    c0_store,
    input  logic [ADDRESS_BITS-1:0] c0_address,
    input  logic [DATA_WIDTH-1:0]   c0_store_data,
    output logic                    c0_stall,
    output logic                    c0_done,
    output logic [DATA_WIDTH-1:0]   c0_load_data,
    input  logic                    c1_load,
    input  logic                    c1_store,
    input  logic [ADDRESS_BITS-1:0] c1_address,
    input  logic [DATA_WIDTH-1:0]   c1_store_data,
    output logic                    c1_stall,
    output logic                    c1_done,
    output logic [DATA_WIDTH-1:0]   c1_load_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output arb_dbg_t                dbg
);

    // Memory handshake: mem_req and its fields are held stable from grant until
    // a posedge samples mem_ready=1; mem_rvalid is consumed only in WAIT_RD.
    arb_state_t            state, next_state;
    logic                  owner;
    logic                  last_grant;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  c0_req, c1_req;
    logic                  grant_valid, grant_idx;
    logic                  sel_store;
    logic                  done_now;

    assign c0_req = c0_load | c0_store;
    assign c1_req = c1_load | c1_store;

    rr_arb2 u_rr_arb2 (
        .req         ({c1_req, c0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A simultaneous load+store is issued as a store.
    assign sel_store = (grant_idx == OWNER_C1) ? c1_store : c0_store;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = REQ;
            REQ:     if (mem_ready)   next_state = mem_we ? DONE : WAIT_RD;
            WAIT_RD: if (mem_rvalid)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWNER_C0;
            last_grant  <= OWNER_C1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rdata_q     <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && grant_valid) begin
                owner       <= grant_idx;
                last_grant  <= grant_idx;
                mem_req     <= 1'b1;
                mem_we      <= sel_store;
                mem_address <= (grant_idx == OWNER_C1) ? c1_address : c0_address;
                mem_wdata   <= (grant_idx == OWNER_C1) ? c1_store_data : c0_store_data;
                rdata_q     <= '0;
            end
            if (state == REQ && mem_ready) begin
                mem_req <= 1'b0;
            end
            if (state == WAIT_RD && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign done_now = (state == DONE);

    assign c0_done      = done_now & (owner == OWNER_C0);
    assign c1_done      = done_now & (owner == OWNER_C1);
    assign c0_load_data = c0_done ? rdata_q : '0;
    assign c1_load_data = c1_done ? rdata_q : '0;

    // The stall drops only in the owner's DONE cycle, letting its pipeline advance.
    assign c0_stall = c0_req & ~c0_done;
    assign c1_stall = c1_req & ~c1_done;

    assign dbg = '{state: state, owner: owner, last_grant: last_grant};

endmodule
